checker_di_multi: RTL

CHECKER_DI_MULTI -- requirements
Module: checker_di_multi

---
 rtl/chk_pkg.sv | 46 ++++
 rtl/crc_chk_calc.sv | 18 +
 rtl/checker_di_multi.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/chk_pkg.sv
// Shared types and helpers for the packet-builder data-integrity checker:
// state encoding, packing-mode codes and the source-byte selection rules.
package chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_CRC_CALC  = 3'd2,
    ST_WAIT_IRQ  = 3'd3,
    ST_COMPARE   = 3'd4,
    ST_CHECK_CRC = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [3:0] OP0      = 4'd0;  // keep every 4th byte
  localparam logic [3:0] OP1      = 4'd1;  // keep first two of every 4
  localparam int         HDR_LEN  = 2;
  localparam logic [7:0] CRC_INIT = 8'h00;
  localparam logic [7:0] CRC_POLY = 8'h07;  // x^8 + x^2 + x + 1, MSB first

  function automatic logic is_selected(input logic [3:0] sel, input logic [3:0] j);
    case (sel)
      OP0:     return j[1:0] == 2'd0;
      OP1:     return !j[1];
      default: return 1'b1;
    endcase
  endfunction

  // Position of source byte j inside the packed payload.
  function automatic logic [3:0] compact_idx(input logic [3:0] sel, input logic [3:0] j);
    case (sel)
      OP0:     return {2'b00, j[3:2]};
      OP1:     return {1'b0, j[3:2], j[0]};
      default: return j;
    endcase
  endfunction

  function automatic logic [4:0] sel_count(input logic [3:0] sel, input logic [3:0] cnt);
    logic [4:0] n;
    n = '0;
    for (int j = 0; j < 16; j++)
      if (4'(j) <= cnt && is_selected(sel, 4'(j))) n = n + 5'd1;
    return n;
  endfunction

endpackage

// File: rtl/crc_chk_calc.sv
// One-byte CRC-8 step (poly 0x07, MSB first, no reflection, no final xor).
module crc_chk_calc
  import chk_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int b = 0; b < 8; b++)
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    crc_out = c;
  end

endmodule

// File: rtl/checker_di_multi.sv
// Samples source bytes, recomputes the packet CRC, then reads the built packet
// back and flags data/CRC mismatches with a saturating error counter.
module checker_di_multi
  import chk_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ADDR_W      = 14,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     checker_en,
  input  logic                     pb_start,
  input  logic                     pb_irq_top,
  input  logic                     pb_crc_en,
  input  logic [7:0]               pb_crc_val,
  input  logic [31:0]              pb_addr_in,
  input  logic [31:0]              pb_addr_out,
  input  logic [3:0]               pb_data_sel,
  input  logic [3:0]               pb_byte_cnt,
  input  logic [4*NUM_SAMPLES-1:0] chosen_bytes,
  input  logic [31:0]              inmem_data_b_o,
  input  logic [31:0]              outmem_data_b_o,
  output logic [ADDR_W-1:0]        inmem_addr_o,
  output logic [ADDR_W-1:0]        outmem_addr_o,
  output logic [2:0]               state_o,
  output logic                     di_err,
  output logic                     di_crc_err,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic                     busy,
  output logic                     done
);

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [7:0]           cap     [NUM_SAMPLES];
  logic [3:0]           cap_off [NUM_SAMPLES];
  logic [7:0]           crc_q, exp_crc, crc_nxt;
  logic                 irq_latch;
  logic [ERR_CNT_W-1:0] err_q;

  logic [3:0]  cur_off_in, cur_off;
  logic [7:0]  cur_cap;
  logic        last_sample, byte_sel, sample_valid, smp_mis, crc_mis;
  logic [ADDR_W-1:0] in_base, out_pkt;
  logic        unused_bits;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_off_in = '0;
    cur_off    = '0;
    cur_cap    = '0;
    for (int i = 0; i < NUM_SAMPLES; i++)
      if (cnt == 4'(i)) begin
        cur_off_in = chosen_bytes[4*i +: 4];
        cur_off    = cap_off[i];
        cur_cap    = cap[i];
      end
  end

  assign last_sample  = cnt == 4'(NUM_SAMPLES - 1);
  assign byte_sel     = is_selected(pb_data_sel, cnt);
  assign sample_valid = cur_off <= pb_byte_cnt && is_selected(pb_data_sel, cur_off);
  assign smp_mis      = state == ST_COMPARE && sample_valid && outmem_data_b_o[7:0] != cur_cap;
  assign crc_mis      = state == ST_CHECK_CRC && outmem_data_b_o[7:0] != exp_crc;

  crc_chk_calc u_crc (
    .crc_in  (crc_q),
    .data_in (inmem_data_b_o[7:0]),
    .crc_out (crc_nxt)
  );

  assign in_base = pb_addr_in[ADDR_W-1:0];
  assign out_pkt = pb_addr_out[ADDR_W-1:0] + ADDR_W'(HDR_LEN);

  always_comb begin
    inmem_addr_o  = '0;
    outmem_addr_o = '0;
    case (state)
      ST_CAPTURE:   inmem_addr_o  = in_base + ADDR_W'(cur_off_in);
      ST_CRC_CALC:  inmem_addr_o  = in_base + ADDR_W'(cnt);
      ST_COMPARE:   outmem_addr_o = out_pkt + ADDR_W'(compact_idx(pb_data_sel, cur_off));
      ST_CHECK_CRC: outmem_addr_o = out_pkt + ADDR_W'(sel_count(pb_data_sel, pb_byte_cnt));
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (pb_start && checker_en) state_nxt = ST_CAPTURE;
      ST_CAPTURE:   if (last_sample) state_nxt = pb_crc_en ? ST_CRC_CALC : ST_WAIT_IRQ;
      ST_CRC_CALC:  if (cnt == pb_byte_cnt) state_nxt = ST_WAIT_IRQ;
      ST_WAIT_IRQ:  if (pb_irq_top || irq_latch) state_nxt = ST_COMPARE;
      ST_COMPARE:   if (last_sample) state_nxt = ST_CHECK_CRC;
      ST_CHECK_CRC: state_nxt = ST_DONE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      crc_q     <= CRC_INIT;
      exp_crc   <= CRC_INIT;
      irq_latch <= 1'b0;
      err_q     <= '0;
      // NOTE: the sample store is cleared on reset because an aborted packet
      // must not leave stale bytes behind; large RAMs would normally not be.
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        cap[i]     <= '0;
        cap_off[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      // The phase counter restarts whenever the state changes.
      cnt   <= (state_nxt != state) ? '0 : cnt + 4'd1;

      if (state == ST_CAPTURE)
        for (int i = 0; i < NUM_SAMPLES; i++)
          if (cnt == 4'(i)) begin
            cap[i]     <= inmem_data_b_o[7:0];
            cap_off[i] <= cur_off_in;
          end

      if (state == ST_CAPTURE && last_sample) begin
        crc_q   <= CRC_INIT;
        exp_crc <= pb_crc_val;
      end
      if (state == ST_CRC_CALC && byte_sel) crc_q <= crc_nxt;
      if (state == ST_CRC_CALC && cnt == pb_byte_cnt) exp_crc <= byte_sel ? crc_nxt : crc_q;

      // A completion arriving before WAIT_IRQ is remembered until consumed.
      if (state == ST_CAPTURE || state == ST_CRC_CALC) irq_latch <= irq_latch | pb_irq_top;
      else                                             irq_latch <= 1'b0;

      if ((smp_mis || crc_mis) && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
    end
  end

  assign state_o    = state;
  assign busy       = state != ST_IDLE;
  assign done       = state == ST_DONE;
  assign di_err     = smp_mis & ~reset;
  assign di_crc_err = crc_mis & ~reset;
  assign err_cnt    = err_q;

  assign unused_bits = ^{inmem_data_b_o[31:8], outmem_data_b_o[31:8], pb_addr_in, pb_addr_out};

endmodule
